unary_add_seq: RTL

UNARY_ADD_SEQ -- requirements
Module: unary_add_seq

---
 rtl/unary_add_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/unary_add_seq.sv
// unary_add_seq: feeds two binary operands to a serial unary adder as thermometer streams and counts the unary result back to binary
module unary_add_seq #(
    parameter int LEN = 15,
    parameter int OW  = 4,
    parameter int WIN = 32,
    parameter int SW  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [OW-1:0] a_val,
    input  logic [OW-1:0] b_val,
    output logic          ua_rst_n,
    output logic          ua_en,
    output logic          ua_rw,
    output logic          ua_A,
    output logic          ua_B,
    input  logic          ua_dout,
    input  logic          ua_C,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [SW-1:0] rsp_sum,
    output logic          rsp_ovf
);
    localparam int KW = $clog2((LEN > WIN ? LEN : WIN) + 1);
    localparam int CW = KW > OW ? KW : OW;

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, RESP} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] a_q, a_d, b_q, b_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          ovf_q, ovf_d;
    logic          req_ready_q, req_ready_d;
    logic          ua_rst_n_q, ua_rst_n_d;
    logic          ua_en_q, ua_en_d;
    logic          ua_rw_q, ua_rw_d;
    logic          ua_a_q, ua_a_d;
    logic          ua_b_q, ua_b_d;
    logic          rsp_valid_q, rsp_valid_d;

    // Next state, phase counter, result accumulation, and outputs derived from the next state so they register cleanly
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                a_d     = a_val > OW'(LEN) ? OW'(LEN) : a_val;
                b_d     = b_val > OW'(LEN) ? OW'(LEN) : b_val;
                state_d = CLR;
            end
            CLR: begin
                sum_d   = '0;
                ovf_d   = 1'b0;
                k_d     = '0;
                state_d = FEED;
            end
            FEED: begin
                k_d     = k_q == KW'(LEN - 1) ? '0 : k_q + 1'b1;
                state_d = k_q == KW'(LEN - 1) ? DRAIN : FEED;
            end
            DRAIN: begin
                if (ua_dout) begin
                    if (sum_q == '1) ovf_d = 1'b1;
                    else sum_d = sum_q + 1'b1;
                end
                if (ua_C) ovf_d = 1'b1;
                k_d     = k_q == KW'(WIN - 1) ? '0 : k_q + 1'b1;
                state_d = k_q == KW'(WIN - 1) ? RESP : DRAIN;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = state_d == IDLE;
        ua_rst_n_d  = state_d != CLR;
        ua_en_d     = state_d == FEED || state_d == DRAIN;
        ua_rw_d     = state_d == DRAIN;
        ua_a_d      = state_d == FEED && CW'(k_d) < CW'(a_d);
        ua_b_d      = state_d == FEED && CW'(k_d) < CW'(b_d);
        rsp_valid_d = state_d == RESP;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            req_ready_q <= 1'b1;
            ua_rst_n_q  <= 1'b0;
            ua_en_q     <= 1'b0;
            ua_rw_q     <= 1'b0;
            ua_a_q      <= 1'b0;
            ua_b_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            req_ready_q <= req_ready_d;
            ua_rst_n_q  <= ua_rst_n_d;
            ua_en_q     <= ua_en_d;
            ua_rw_q     <= ua_rw_d;
            ua_a_q      <= ua_a_d;
            ua_b_q      <= ua_b_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign ua_rst_n  = ua_rst_n_q;
    assign ua_en     = ua_en_q;
    assign ua_rw     = ua_rw_q;
    assign ua_A      = ua_a_q;
    assign ua_B      = ua_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_ovf   = ovf_q;
endmodule
